// File: rtl/vt52_key_encoder.sv
// vt52_key_encoder: keyboard-to-host byte source expanding special keys into VT52 ESC sequences.
// Define IDENT_RESPONSE_EN to answer host identify requests with ESC / IDENT_SUFFIX.
module vt52_key_encoder #(
    parameter logic [7:0] SPECIAL_BASE = 8'h80,
    parameter logic [7:0] IDENT_SUFFIX = 8'h4B
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] key_data,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic       ident_req,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);
    typedef enum logic [1:0] {IDLE, SEND0, SEND1, SEND2} state_t;
    state_t state_q, state_d;
    logic [2:0][7:0] seq_q, seq_d;
    logic [1:0] len_q, len_d;
    logic pend_q, pend_d;
    logic ident_in, ident_now;
    logic [7:0] off;
    logic plain, arrow, pf;
`ifdef IDENT_RESPONSE_EN
    assign ident_in = ident_req;
    // an identify pulse arriving in IDLE beats a simultaneous key, so the key is refused
    assign key_ready = state_q == IDLE && !ident_now && !reset;
`else
    logic unused_ident;
    assign unused_ident = ident_req;
    assign ident_in = 1'b0;
    assign key_ready = state_q == IDLE;
`endif
    assign ident_now = pend_q | ident_in;
    assign off = key_data - SPECIAL_BASE;
    assign plain = key_data < 8'h80;
    assign arrow = !plain && key_data >= SPECIAL_BASE && off < 8'd4;
    assign pf = !plain && key_data >= SPECIAL_BASE && off >= 8'd4 && off < 8'd7;
    assign out_valid = state_q != IDLE;
    assign out_data = state_q == SEND0 ? seq_q[0] :
                      state_q == SEND1 ? seq_q[1] :
                      state_q == SEND2 ? seq_q[2] : 8'h00;
    always_comb begin
        state_d = state_q;
        seq_d = seq_q;
        len_d = len_q;
        pend_d = ident_now;
        if (state_q == IDLE) begin
            if (ident_now) begin
                seq_d = {IDENT_SUFFIX, 8'h2F, 8'h1B};
                len_d = 2'd3;
                pend_d = 1'b0;
                state_d = SEND0;
            end else if (key_valid && key_ready && (plain || arrow || pf)) begin
                seq_d = plain ? {16'h0000, key_data} :
                        arrow ? {8'h00, 8'h41 + off, 8'h1B} : {8'h00, 8'h4C + off, 8'h1B};
                len_d = plain ? 2'd1 : 2'd2;
                state_d = SEND0;
            end
        end else if (out_ready) begin
            state_d = (state_q == SEND0 && len_q > 2'd1) ? SEND1 :
                      (state_q == SEND1 && len_q > 2'd2) ? SEND2 : IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            seq_q <= '0;
            len_q <= 2'd0;
            pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q <= seq_d;
            len_q <= len_d;
            pend_q <= pend_d;
        end
    end
endmodule

// File: tb/tb_vt52_key_encoder.sv
// tb_vt52_key_encoder: table-driven key vectors plus directed stall, identify and reset sequences.
module tb_vt52_key_encoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] key_data = 8'h00;
    logic key_valid = 1'b0;
    logic key_ready;
    logic ident_req = 1'b0;
    logic [7:0] out_data;
    logic out_valid;
    logic out_ready = 1'b0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]      key;
        logic [2:0][7:0] exp;
        int              n;
    } vec_t;
    vec_t vecs[13];

    vt52_key_encoder dut (
        .clk(clk), .reset(reset), .key_data(key_data), .key_valid(key_valid),
        .key_ready(key_ready), .ident_req(ident_req), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic accept_key(input logic [7:0] k);
        int t = 0;
        key_data = k;
        key_valid = 1'b1;
        while (!key_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("key_accept_timeout", 32'(t < 20), 1);
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic expect_bytes(input string name, input logic [2:0][7:0] exp, input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            int t = 0;
            while (!out_valid && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk({name, "_timeout"}, 32'(t < 20), 1);
            chk(name, out_data, exp[i]);
            @(negedge clk);
        end
        chk({name, "_idle_after"}, out_valid, 0);
    endtask

    task automatic quiet(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            chk(name, out_valid, 0);
            @(negedge clk);
        end
    endtask

    task automatic pulse_ident();
        ident_req = 1'b1;
        @(negedge clk);
        ident_req = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{8'h61, {8'h00, 8'h00, 8'h61}, 1};
        vecs[1]  = '{8'h80, {8'h00, 8'h41, 8'h1B}, 2};
        vecs[2]  = '{8'h81, {8'h00, 8'h42, 8'h1B}, 2};
        vecs[3]  = '{8'h82, {8'h00, 8'h43, 8'h1B}, 2};
        vecs[4]  = '{8'h83, {8'h00, 8'h44, 8'h1B}, 2};
        vecs[5]  = '{8'h84, {8'h00, 8'h50, 8'h1B}, 2};
        vecs[6]  = '{8'h85, {8'h00, 8'h51, 8'h1B}, 2};
        vecs[7]  = '{8'h86, {8'h00, 8'h52, 8'h1B}, 2};
        vecs[8]  = '{8'h87, {8'h00, 8'h00, 8'h00}, 0};
        vecs[9]  = '{8'h90, {8'h00, 8'h00, 8'h00}, 0};
        vecs[10] = '{8'hFF, {8'h00, 8'h00, 8'h00}, 0};
        vecs[11] = '{8'h00, {8'h00, 8'h00, 8'h00}, 1};
        vecs[12] = '{8'h7F, {8'h00, 8'h00, 8'h7F}, 1};

        repeat (2) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 8'h00);
`ifdef IDENT_RESPONSE_EN
        chk("reset_key_ready", key_ready, 0);
`else
        chk("reset_key_ready", key_ready, 1);
`endif
        reset = 1'b0;
        @(negedge clk);
        chk("idle_key_ready", key_ready, 1);

        out_ready = 1'b1;
        for (int v = 0; v < 13; v++) begin
            accept_key(vecs[v].key);
            chk($sformatf("latency_valid_%0h", vecs[v].key), out_valid, 32'(vecs[v].n > 0));
            if (vecs[v].n > 0) expect_bytes($sformatf("key_%0h", vecs[v].key), vecs[v].exp, vecs[v].n);
            else quiet($sformatf("dropped_%0h", vecs[v].key), 3);
            chk($sformatf("ready_after_%0h", vecs[v].key), key_ready, 1);
        end

        out_ready = 1'b0;
        accept_key(8'h80);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, 8'h1B);
            @(negedge clk);
        end
        expect_bytes("stall_seq", {8'h00, 8'h41, 8'h1B}, 2);

        pulse_ident();
`ifdef IDENT_RESPONSE_EN
        expect_bytes("ident", {8'h4B, 8'h2F, 8'h1B}, 3);
`else
        quiet("ident_disabled", 5);
`endif

        out_ready = 1'b0;
        accept_key(8'h83);
        repeat (3) pulse_ident();
        expect_bytes("key_then_ident", {8'h00, 8'h44, 8'h1B}, 2);
`ifdef IDENT_RESPONSE_EN
        chk("pending_blocks_key", key_ready, 0);
        expect_bytes("coalesced_ident", {8'h4B, 8'h2F, 8'h1B}, 3);
`endif
        quiet("single_reply", 6);

`ifdef IDENT_RESPONSE_EN
        key_data = 8'h61;
        key_valid = 1'b1;
        ident_req = 1'b1;
        @(negedge clk);
        ident_req = 1'b0;
        chk("ident_wins_ready", key_ready, 0);
        chk("ident_wins_first", out_data, 8'h1B);
        expect_bytes("ident_wins", {8'h4B, 8'h2F, 8'h1B}, 3);
        accept_key(8'h61);
        expect_bytes("held_key", {8'h00, 8'h00, 8'h61}, 1);
`endif

        out_ready = 1'b1;
        accept_key(8'h82);
        chk("rst_seq_byte0", out_data, 8'h1B);
        pulse_ident();
        out_ready = 1'b0;
        reset = 1'b1;
        chk("rst_seq_byte1_shown", out_data, 8'h43);
        @(negedge clk);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_data", out_data, 8'h00);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_idle_ready", key_ready, 1);
        quiet("rst_abandoned", 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
